// File: rtl/sram_port_arbiter_if.sv
// IF/DM requester ports and off-chip SRAM pins of sram_port_arbiter.
// slave = arbiter side, master = requesters plus SRAM device.
interface sram_port_arbiter_if #(
    parameter int unsigned WADDR_W = 19
);
    logic               i_if_req;
    logic [WADDR_W-1:0] i_if_addr;
    logic               o_if_ready;
    logic [31:0]        o_if_rdata;
    logic               o_if_stall;

    logic               i_dm_req;
    logic               i_dm_we;
    logic [WADDR_W-1:0] i_dm_addr;
    logic [31:0]        i_dm_wdata;
    logic [3:0]         i_dm_be;
    logic               o_dm_ready;
    logic [31:0]        o_dm_rdata;
    logic               o_dm_stall;

    logic [WADDR_W:0]   o_SRAM_ADDR;
    logic [15:0]        o_SRAM_DQ;
    logic               o_SRAM_DQ_OE;
    logic [15:0]        i_SRAM_DQ;
    logic               o_SRAM_CE_N;
    logic               o_SRAM_OE_N;
    logic               o_SRAM_WE_N;
    logic               o_SRAM_LB_N;
    logic               o_SRAM_UB_N;

    modport slave (
        input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be, i_SRAM_DQ,
        output o_if_ready, o_if_rdata, o_if_stall, o_dm_ready, o_dm_rdata, o_dm_stall,
        output o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_OE,
        output o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N
    );

    modport master (
        output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be, i_SRAM_DQ,
        input  o_if_ready, o_if_rdata, o_if_stall, o_dm_ready, o_dm_rdata, o_dm_stall,
        input  o_SRAM_ADDR, o_SRAM_DQ, o_SRAM_DQ_OE,
        input  o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit SRAM between IF and DM ports; each 32-bit access is two half-word phases.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed DM-over-IF priority.
module sram_port_arbiter #(
    parameter int unsigned ACC_CYC = 2,
    parameter int unsigned WADDR_W = 19
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sram_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BE_W   = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt_dm_q, gnt_dm_d;
    logic               we_q, we_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;

    logic               any_req_c, pick_dm_c, phase_last_c, half_hi_c;

    logic               ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q, dq_oe_q;
    logic               ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, dq_oe_d;
    logic [WADDR_W:0]   sram_addr_q, sram_addr_d;
    logic [HALF_W-1:0]  dq_q, dq_d;
    logic               if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
    logic [HALF_W-1:0]  rd_lo_q;
    logic [DATA_W-1:0]  if_rdata_q, dm_rdata_q;

    assign any_req_c    = bus.i_if_req | bus.i_dm_req;
    assign phase_last_c = (cnt_q == CNT_LAST);
    assign half_hi_c    = (state_d == ST_HI);

`ifdef SRAM_ARB_RR_EN
    // last_dm_q = 1 when DM was granted most recently; the other port wins a tie
    logic last_dm_q;
    assign pick_dm_c = bus.i_dm_req & (~bus.i_if_req | ~last_dm_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                              last_dm_q <= 1'b0;
        else if (state_q == ST_IDLE && any_req_c)  last_dm_q <= pick_dm_c;
    end
`else
    assign pick_dm_c = bus.i_dm_req;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt_dm_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_dm_q <= gnt_dm_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    // Next state; write phases with no enabled byte are skipped
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_dm_d = gnt_dm_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    gnt_dm_d = pick_dm_c;
                    we_d     = pick_dm_c & bus.i_dm_we;
                    addr_d   = pick_dm_c ? bus.i_dm_addr : bus.i_if_addr;
                    wdata_d  = bus.i_dm_wdata;
                    be_d     = (pick_dm_c & bus.i_dm_we) ? bus.i_dm_be : {BE_W{1'b1}};
                    cnt_d    = '0;
                    if (be_d[1:0] != 2'b00)      state_d = ST_LO;
                    else if (be_d[3:2] != 2'b00) state_d = ST_HI;
                    else                         state_d = ST_DONE;
                end
            end
            ST_LO: begin
                if (phase_last_c) begin
                    cnt_d   = '0;
                    state_d = (be_q[3:2] != 2'b00) ? ST_HI : ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (phase_last_c) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so pins are registered yet aligned with the phase
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_d        = dq_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if (state_d == ST_LO || state_d == ST_HI) begin
            ce_n_d      = 1'b0;
            sram_addr_d = {addr_d, half_hi_c};
            if (we_d) begin
                dq_oe_d = 1'b1;
                we_n_d  = (cnt_d == CNT_LAST);
                dq_d    = half_hi_c ? wdata_d[31:16] : wdata_d[15:0];
                lb_n_d  = ~(half_hi_c ? be_d[2] : be_d[0]);
                ub_n_d  = ~(half_hi_c ? be_d[3] : be_d[1]);
            end else begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end
        if (state_d == ST_DONE) begin
            if_ready_d = ~gnt_dm_d;
            dm_ready_d = gnt_dm_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_q        <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
            dq_oe_q     <= dq_oe_d;
            sram_addr_q <= sram_addr_d;
            dq_q        <= dq_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
        end
    end

    // Read data captured on the last cycle of each phase; writes leave rdata untouched
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_lo_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else if (!we_q && phase_last_c) begin
            if (state_q == ST_LO) rd_lo_q <= bus.i_SRAM_DQ;
            if (state_q == ST_HI) begin
                if (gnt_dm_q) dm_rdata_q <= {bus.i_SRAM_DQ, rd_lo_q};
                else          if_rdata_q <= {bus.i_SRAM_DQ, rd_lo_q};
            end
        end
    end

    assign bus.o_if_ready   = if_ready_q;
    assign bus.o_dm_ready   = dm_ready_q;
    assign bus.o_if_rdata   = if_rdata_q;
    assign bus.o_dm_rdata   = dm_rdata_q;
    assign bus.o_if_stall   = bus.i_if_req & ~if_ready_q;
    assign bus.o_dm_stall   = bus.i_dm_req & ~dm_ready_q;
    assign bus.o_SRAM_ADDR  = sram_addr_q;
    assign bus.o_SRAM_DQ    = dq_q;
    assign bus.o_SRAM_DQ_OE = dq_oe_q;
    assign bus.o_SRAM_CE_N  = ce_n_q;
    assign bus.o_SRAM_OE_N  = oe_n_q;
    assign bus.o_SRAM_WE_N  = we_n_q;
    assign bus.o_SRAM_LB_N  = lb_n_q;
    assign bus.o_SRAM_UB_N  = ub_n_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: vector table of single accesses plus
// arbitration, mid-access reset and ACC_CYC=4 sequences against an SRAM model.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
    localparam int unsigned WADDR_W = 19;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.WADDR_W(WADDR_W)) bus  ();
    sram_port_arbiter_if #(.WADDR_W(WADDR_W)) bus4 ();

    sram_port_arbiter #(.ACC_CYC(2), .WADDR_W(WADDR_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    sram_port_arbiter #(.ACC_CYC(4), .WADDR_W(WADDR_W)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4)
    );

    // SRAM model: async read, byte-lane write on clock while WE_N low
    logic [15:0] mem [256];

    assign bus.i_SRAM_DQ = (!bus.o_SRAM_CE_N && !bus.o_SRAM_OE_N) ? mem[bus.o_SRAM_ADDR[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
            mem[8'h20] <= 16'h1234;
            mem[8'h21] <= 16'hABCD;
        end else if (!bus.o_SRAM_CE_N && !bus.o_SRAM_WE_N && bus.o_SRAM_DQ_OE) begin
            if (!bus.o_SRAM_LB_N) mem[bus.o_SRAM_ADDR[7:0]][7:0]  <= bus.o_SRAM_DQ[7:0];
            if (!bus.o_SRAM_UB_N) mem[bus.o_SRAM_ADDR[7:0]][15:8] <= bus.o_SRAM_DQ[15:8];
        end
    end

    // Slow-SRAM model for the ACC_CYC=4 instance: data only valid on the 4th cycle of a phase
    logic        p_oe_n4;
    logic [19:0] p_addr4;
    int          p_idx4;
    int          cur_idx4;

    always_comb begin
        cur_idx4 = 0;
        if (!bus4.o_SRAM_OE_N && !p_oe_n4 && bus4.o_SRAM_ADDR == p_addr4) cur_idx4 = p_idx4 + 1;
    end

    always @(posedge clk) begin
        p_oe_n4 <= bus4.o_SRAM_OE_N;
        p_addr4 <= bus4.o_SRAM_ADDR;
        p_idx4  <= cur_idx4;
    end

    assign bus4.i_SRAM_DQ = (!bus4.o_SRAM_OE_N && cur_idx4 == 3) ? mem[bus4.o_SRAM_ADDR[7:0]] : 16'hFFFF;

    typedef struct {
        logic        dm;
        logic        we;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] word;   // read data, or memory word after a write
        int          wel;    // cycles with WE_N low
    } vec_t;

    vec_t        vecs [9];
    int          n_tests;
    int          n_fail;
    int          obs_wel;
    logic [19:0] obs_addr;
    logic        obs_lb_n, obs_ub_n, obs_oe;
    logic [31:0] dm_rd_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Call right after a negedge; returns at the negedge of the ready cycle (or after a 40-cycle bound)
    task automatic do_access(input logic dm, input logic we, input logic [18:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output int lat, output int stall_cyc);
        if (dm) begin
            bus.i_dm_req = 1'b1; bus.i_dm_we = we; bus.i_dm_addr = addr;
            bus.i_dm_wdata = wdata; bus.i_dm_be = be;
        end else begin
            bus.i_if_req = 1'b1; bus.i_if_addr = addr;
        end
        lat = 0; stall_cyc = 0; obs_wel = 0;
        #1;
        if (dm ? bus.o_dm_stall : bus.o_if_stall) stall_cyc++;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (!bus.o_SRAM_WE_N) begin
                obs_wel++;
                obs_addr = bus.o_SRAM_ADDR;
                obs_lb_n = bus.o_SRAM_LB_N;
                obs_ub_n = bus.o_SRAM_UB_N;
                obs_oe   = bus.o_SRAM_DQ_OE;
            end
            if (dm ? bus.o_dm_ready : bus.o_if_ready) break;
            if (dm ? bus.o_dm_stall : bus.o_if_stall) stall_cyc++;
        end
        bus.i_if_req = 1'b0;
        bus.i_dm_req = 1'b0;
    endtask

    int          lat, stall_cyc, if_at, dm_at, exp_if_at, exp_dm_at;
    logic [7:0]  ia;
    logic [31:0] act_word;

    initial begin
        n_tests = 0; n_fail = 0; dm_rd_model = 32'h0;
        obs_addr = '0; obs_lb_n = 1'b1; obs_ub_n = 1'b1; obs_oe = 1'b0;
        rst_n = 1'b0;
        bus.i_if_req = 0; bus.i_if_addr = '0; bus.i_dm_req = 0; bus.i_dm_we = 0;
        bus.i_dm_addr = '0; bus.i_dm_wdata = '0; bus.i_dm_be = '0;
        bus4.i_if_req = 0; bus4.i_if_addr = '0; bus4.i_dm_req = 0; bus4.i_dm_we = 0;
        bus4.i_dm_addr = '0; bus4.i_dm_wdata = '0; bus4.i_dm_be = '0;

        //            dm    we    addr      wdata         be       lat word          wel
        vecs[0] = '{1'b0, 1'b0, 19'h10, 32'h0,        4'b1111, 5, 32'hABCD1234, 0};
        vecs[1] = '{1'b1, 1'b1, 19'h03, 32'hDEADBEEF, 4'b1111, 5, 32'hDEADBEEF, 2};
        vecs[2] = '{1'b1, 1'b0, 19'h03, 32'h0,        4'b0000, 5, 32'hDEADBEEF, 0};
        vecs[3] = '{1'b1, 1'b1, 19'h03, 32'h00AA0000, 4'b0100, 3, 32'hDEAABEEF, 1};
        vecs[4] = '{1'b1, 1'b1, 19'h03, 32'h11223344, 4'b0011, 3, 32'hDEAA3344, 1};
        vecs[5] = '{1'b1, 1'b1, 19'h03, 32'h99999999, 4'b0000, 1, 32'hDEAA3344, 0};
        vecs[6] = '{1'b1, 1'b1, 19'h03, 32'h55667788, 4'b1001, 5, 32'h55AA3388, 2};
        vecs[7] = '{1'b0, 1'b0, 19'h03, 32'h0,        4'b0000, 5, 32'h55AA3388, 0};
        vecs[8] = '{1'b1, 1'b0, 19'h10, 32'h0,        4'b0000, 5, 32'hABCD1234, 0};

        repeat (3) @(negedge clk);
        check("reset_ctrl_pins", {26'h0, bus.o_SRAM_CE_N, bus.o_SRAM_OE_N, bus.o_SRAM_WE_N,
              bus.o_SRAM_LB_N, bus.o_SRAM_UB_N, bus.o_SRAM_DQ_OE}, 32'h3E);
        check("reset_addr_dq", {bus.o_SRAM_ADDR[15:0], bus.o_SRAM_DQ}, 32'h0);
        check("reset_ready", {30'h0, bus.o_if_ready, bus.o_dm_ready}, 32'h0);
        check("reset_rdata", bus.o_if_rdata | bus.o_dm_rdata, 32'h0);

        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_access(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, stall_cyc);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_stall_cycles", i), 32'(stall_cyc), 32'(vecs[i].lat));
            check($sformatf("v%0d_we_low_cycles", i), 32'(obs_wel), 32'(vecs[i].wel));
            if (vecs[i].we) begin
                ia = {vecs[i].addr[6:0], 1'b0};
                act_word = {mem[ia + 8'd1], mem[ia]};
                check($sformatf("v%0d_mem_word", i), act_word, vecs[i].word);
                check($sformatf("v%0d_dm_rdata_kept", i), bus.o_dm_rdata, dm_rd_model);
                if (vecs[i].wel != 0) check($sformatf("v%0d_dq_oe", i), {31'h0, obs_oe}, 32'h1);
            end else begin
                act_word = vecs[i].dm ? bus.o_dm_rdata : bus.o_if_rdata;
                check($sformatf("v%0d_rdata", i), act_word, vecs[i].word);
                if (vecs[i].dm) dm_rd_model = vecs[i].word;
            end
            if (i == 3) check("v3_hi_only_pins", {11'h0, obs_addr, obs_lb_n}, {11'h0, 20'h7, 1'b0} | 32'h0);
            if (i == 3) check("v3_ub_n", {31'h0, obs_ub_n}, 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_ready_pulse", i), {30'h0, bus.o_if_ready, bus.o_dm_ready}, 32'h0);
        end

        // Simultaneous requests; one IDLE cycle separates the two accesses
`ifdef SRAM_ARB_RR_EN
        exp_if_at = 5;  exp_dm_at = 11;
`else
        exp_dm_at = 5;  exp_if_at = 11;
`endif
        bus.i_if_req = 1'b1; bus.i_if_addr = 19'h10;
        bus.i_dm_req = 1'b1; bus.i_dm_we = 1'b0; bus.i_dm_addr = 19'h03;
        if_at = 0; dm_at = 0;
        for (int c = 1; c <= 30 && (if_at == 0 || dm_at == 0); c++) begin
            @(negedge clk);
            if (bus.o_if_ready) begin if_at = c; bus.i_if_req = 1'b0; end
            if (bus.o_dm_ready) begin dm_at = c; bus.i_dm_req = 1'b0; end
        end
        bus.i_if_req = 1'b0; bus.i_dm_req = 1'b0;
        check("arb_dm_ready_cycle", 32'(dm_at), 32'(exp_dm_at));
        check("arb_if_ready_cycle", 32'(if_at), 32'(exp_if_at));
        check("arb_dm_rdata", bus.o_dm_rdata, 32'h55AA3388);
        check("arb_if_rdata", bus.o_if_rdata, 32'hABCD1234);
        @(negedge clk);

        // Reset during the HI phase of an IF read
        bus.i_if_req = 1'b1; bus.i_if_addr = 19'h10;
        repeat (3) @(negedge clk);
        check("pre_reset_in_hi", {12'h0, bus.o_SRAM_ADDR}, 32'h21);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl_pins", {26'h0, bus.o_SRAM_CE_N, bus.o_SRAM_OE_N, bus.o_SRAM_WE_N,
              bus.o_SRAM_LB_N, bus.o_SRAM_UB_N, bus.o_SRAM_DQ_OE}, 32'h3E);
        check("rst_mid_addr", {12'h0, bus.o_SRAM_ADDR}, 32'h0);
        check("rst_mid_if_rdata", bus.o_if_rdata, 32'h0);
        bus.i_if_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_no_ready", {30'h0, bus.o_if_ready, bus.o_dm_ready}, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle_ready", {30'h0, bus.o_if_ready, bus.o_dm_ready}, 32'h0);
        do_access(1'b0, 1'b0, 19'h10, 32'h0, 4'hF, lat, stall_cyc);
        check("post_rst_latency", 32'(lat), 32'd5);
        check("post_rst_rdata", bus.o_if_rdata, 32'hABCD1234);

        // ACC_CYC=4 read on the second instance
        @(negedge clk);
        bus4.i_if_req = 1'b1; bus4.i_if_addr = 19'h10;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus4.o_if_ready) break;
        end
        bus4.i_if_req = 1'b0;
        check("acc4_latency", 32'(lat), 32'd9);
        check("acc4_rdata", bus4.o_if_rdata, 32'hABCD1234);
        @(negedge clk);
        check("acc4_ready_pulse", {31'h0, bus4.o_if_ready}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
